// File: rtl/multicycle_main_fsm.sv
// Main control FSM for a multicycle ARM-subset core: sequences fetch/decode/execute/writeback
// and issues the unconditional write requests that the conditional-write stage later gates.
module multicycle_main_fsm #(
    parameter int ALUC_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        Op,
    input  logic [5:0]        Funct,
    input  logic [3:0]        Rd,
    output logic              IRWrite,
    output logic              NextPC,
    output logic              AdrSrc,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ResultSrc,
    output logic [ALUC_W-1:0] ALUControl,
    output logic [1:0]        FlagW,
    output logic              PCS,
    output logic              RegW,
    output logic              MemW,
    output logic              NoWrite
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECR   = 4'd6,
        EXECI   = 4'd7,
        ALUWB   = 4'd8,
        BRANCH  = 4'd9,
        UNKNOWN = 4'd10
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       branch;
    logic       alu_dec;
    logic       flag_en;
    logic [1:0] alu_op;
    logic       cmd_known;
    logic       cmd_arith;
    logic [3:0] cmd;

    assign cmd = Funct[4:1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = FETCH;
        case (state)
            FETCH:  state_nxt = DECODE;
            DECODE: begin
                case (Op)
                    2'b01:   state_nxt = MEMADR;
                    2'b00:   state_nxt = Funct[5] ? EXECI : EXECR;
                    2'b10:   state_nxt = BRANCH;
                    default: state_nxt = UNKNOWN;
                endcase
            end
            MEMADR: state_nxt = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_nxt = MEMWB;
            EXECR:  state_nxt = ALUWB;
            EXECI:  state_nxt = ALUWB;
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        RegW      = 1'b0;
        MemW      = 1'b0;
        branch    = 1'b0;
        alu_dec   = 1'b0;
        flag_en   = 1'b0;
        case (state)
            FETCH: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECR: begin
                ALUSrcB = 2'b00;
                alu_dec = 1'b1;
                flag_en = 1'b1;
            end
            EXECI: begin
                ALUSrcB = 2'b01;
                alu_dec = 1'b1;
                flag_en = 1'b1;
            end
            ALUWB: begin
                RegW    = 1'b1;
                alu_dec = 1'b1;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    // Data-processing decode; unrecognised commands fall back to a flagless ADD.
    always_comb begin
        alu_op    = 2'b00;
        cmd_known = 1'b1;
        cmd_arith = 1'b0;
        NoWrite   = 1'b0;
        case (cmd)
            4'b0100: begin alu_op = 2'b00; cmd_arith = 1'b1; end
            4'b0010: begin alu_op = 2'b01; cmd_arith = 1'b1; end
            4'b0000: alu_op = 2'b10;
            4'b1100: alu_op = 2'b11;
            4'b1010: begin alu_op = 2'b01; cmd_arith = 1'b1; NoWrite = alu_dec; end
            default: cmd_known = 1'b0;
        endcase
        if (!alu_dec) begin
            alu_op = 2'b00;
        end
    end

    assign ALUControl = ALUC_W'(alu_op);
    assign FlagW[1]   = flag_en & cmd_known & Funct[0];
    assign FlagW[0]   = flag_en & cmd_known & Funct[0] & cmd_arith;
    assign PCS        = ((Rd == 4'hF) & RegW) | branch;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Scoreboard bench for multicycle_main_fsm: directed instruction sequences with per-cycle
// hand-written expected control vectors.
module tb_multicycle_main_fsm;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       IRWrite, NextPC, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl, FlagW;
    logic       PCS, RegW, MemW, NoWrite;

    multicycle_main_fsm #(.ALUC_W(2)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
        .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] exp_q[$];
    string       name_q[$];
    event        ev_push;
    int          checks = 0;
    int          errors = 0;

    // Vector layout: IRWrite NextPC AdrSrc ALUSrcA ALUSrcB ResultSrc ALUControl FlagW PCS RegW MemW NoWrite
    function automatic logic [15:0] v(input logic irw, input logic npc, input logic adr,
                                      input logic sa, input logic [1:0] sb, input logic [1:0] rs,
                                      input logic [1:0] ac, input logic [1:0] fw, input logic pcs,
                                      input logic rw, input logic mw, input logic nw);
        return {irw, npc, adr, sa, sb, rs, ac, fw, pcs, rw, mw, nw};
    endfunction

    task automatic expect_now(input logic [15:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        ->ev_push;
    endtask

    task automatic step(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                        input logic [15:0] e, input string nm);
        @(negedge clk);
        Op    = op;
        Funct = fn;
        Rd    = rd;
        expect_now(e, nm);
    endtask

    initial begin : monitor
        logic [15:0] got;
        logic [15:0] e;
        string       nm;
        forever begin
            @(ev_push);
            #1;
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                       ALUControl, FlagW, PCS, RegW, MemW, NoWrite};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL %s: got %b required %b", nm, got, e);
                end
            end
        end
    end

    initial begin : stimulus
        logic [15:0] vf, vd;
        vf = v(1, 1, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0);
        vd = v(0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0);
        reset = 1'b0;
        Op    = 2'b00;
        Funct = 6'b0;
        Rd    = 4'h0;

        step(2'b00, 6'b0, 4'h0, vf, "reset_state");
        @(posedge clk);
        #2 reset = 1'b1;

        // ADD register, Rd=3
        step(2'b00, 6'b001000, 4'h3, vf, "add_fetch");
        step(2'b00, 6'b001000, 4'h3, vd, "add_decode");
        step(2'b00, 6'b001000, 4'h3, v(0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0,0), "add_execr");
        step(2'b00, 6'b001000, 4'h3, v(0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,1,0,0), "add_aluwb");

        // LDR
        step(2'b01, 6'b011001, 4'h2, vf, "ldr_fetch");
        step(2'b01, 6'b011001, 4'h2, vd, "ldr_decode");
        step(2'b01, 6'b011001, 4'h2, v(0,0,0,0,2'b01,2'b00,2'b00,2'b00,0,0,0,0), "ldr_memadr");
        step(2'b01, 6'b011001, 4'h2, v(0,0,1,0,2'b00,2'b00,2'b00,2'b00,0,0,0,0), "ldr_memrd");
        step(2'b01, 6'b011001, 4'h2, v(0,0,0,0,2'b00,2'b01,2'b00,2'b00,0,1,0,0), "ldr_memwb");

        // STR
        step(2'b01, 6'b011000, 4'h2, vf, "str_fetch");
        step(2'b01, 6'b011000, 4'h2, vd, "str_decode");
        step(2'b01, 6'b011000, 4'h2, v(0,0,0,0,2'b01,2'b00,2'b00,2'b00,0,0,0,0), "str_memadr");
        step(2'b01, 6'b011000, 4'h2, v(0,0,1,0,2'b00,2'b00,2'b00,2'b00,0,0,1,0), "str_memwr");

        // CMP immediate
        step(2'b00, 6'b110101, 4'h0, vf, "cmp_fetch");
        step(2'b00, 6'b110101, 4'h0, vd, "cmp_decode");
        step(2'b00, 6'b110101, 4'h0, v(0,0,0,0,2'b01,2'b00,2'b01,2'b11,0,0,0,1), "cmp_execi");
        step(2'b00, 6'b110101, 4'h0, v(0,0,0,0,2'b00,2'b00,2'b01,2'b00,0,1,0,1), "cmp_aluwb");

        // ADDS register
        step(2'b00, 6'b001001, 4'h4, vf, "adds_fetch");
        step(2'b00, 6'b001001, 4'h4, vd, "adds_decode");
        step(2'b00, 6'b001001, 4'h4, v(0,0,0,0,2'b00,2'b00,2'b00,2'b11,0,0,0,0), "adds_execr");
        step(2'b00, 6'b001001, 4'h4, v(0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,1,0,0), "adds_aluwb");

        // ORRS register: logical op sets only N,Z
        step(2'b00, 6'b011001, 4'h5, vf, "orrs_fetch");
        step(2'b00, 6'b011001, 4'h5, vd, "orrs_decode");
        step(2'b00, 6'b011001, 4'h5, v(0,0,0,0,2'b00,2'b00,2'b11,2'b10,0,0,0,0), "orrs_execr");
        step(2'b00, 6'b011001, 4'h5, v(0,0,0,0,2'b00,2'b00,2'b11,2'b00,0,1,0,0), "orrs_aluwb");

        // SUB immediate, no S
        step(2'b00, 6'b100100, 4'h6, vf, "subi_fetch");
        step(2'b00, 6'b100100, 4'h6, vd, "subi_decode");
        step(2'b00, 6'b100100, 4'h6, v(0,0,0,0,2'b01,2'b00,2'b01,2'b00,0,0,0,0), "subi_execi");
        step(2'b00, 6'b100100, 4'h6, v(0,0,0,0,2'b00,2'b00,2'b01,2'b00,0,1,0,0), "subi_aluwb");

        // Unrecognised cmd with S=1: no flags, ADD
        step(2'b00, 6'b011111, 4'h7, vf, "unkcmd_fetch");
        step(2'b00, 6'b011111, 4'h7, vd, "unkcmd_decode");
        step(2'b00, 6'b011111, 4'h7, v(0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0,0), "unkcmd_execr");
        step(2'b00, 6'b011111, 4'h7, v(0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,1,0,0), "unkcmd_aluwb");

        // Branch
        step(2'b10, 6'b000000, 4'h0, vf, "b_fetch");
        step(2'b10, 6'b000000, 4'h0, vd, "b_decode");
        step(2'b10, 6'b000000, 4'h0, v(0,0,0,0,2'b01,2'b10,2'b00,2'b00,1,0,0,0), "b_branch");

        // ADD to PC
        step(2'b00, 6'b001000, 4'hF, vf, "addpc_fetch");
        step(2'b00, 6'b001000, 4'hF, vd, "addpc_decode");
        step(2'b00, 6'b001000, 4'hF, v(0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0,0), "addpc_execr");
        step(2'b00, 6'b001000, 4'hF, v(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,1,0,0), "addpc_aluwb");

        // Undefined opcode
        step(2'b11, 6'b000001, 4'hF, vf, "undef_fetch");
        step(2'b11, 6'b000001, 4'hF, vd, "undef_decode");
        step(2'b11, 6'b000001, 4'hF, v(0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0,0), "undef_unknown");

        // LDR interrupted by reset in MEMRD
        step(2'b01, 6'b011001, 4'hF, vf, "rst_fetch");
        step(2'b01, 6'b011001, 4'hF, vd, "rst_decode");
        step(2'b01, 6'b011001, 4'hF, v(0,0,0,0,2'b01,2'b00,2'b00,2'b00,0,0,0,0), "rst_memadr");
        step(2'b01, 6'b011001, 4'hF, v(0,0,1,0,2'b00,2'b00,2'b00,2'b00,0,0,0,0), "rst_memrd");
        #3 reset = 1'b0;
        expect_now(vf, "rst_async_fetch");
        step(2'b01, 6'b011001, 4'hF, vf, "rst_held_fetch");
        @(posedge clk);
        #2 reset = 1'b1;
        step(2'b01, 6'b011001, 4'hF, vf, "rel_fetch");
        step(2'b01, 6'b011001, 4'hF, vd, "rel_decode");
        step(2'b01, 6'b011001, 4'hF, v(0,0,0,0,2'b01,2'b00,2'b00,2'b00,0,0,0,0), "rel_memadr");
        step(2'b01, 6'b011001, 4'hF, v(0,0,1,0,2'b00,2'b00,2'b00,2'b00,0,0,0,0), "rel_memrd");
        step(2'b01, 6'b011001, 4'hF, v(0,0,0,0,2'b00,2'b01,2'b00,2'b00,1,1,0,0), "rel_memwb");
        step(2'b00, 6'b000000, 4'h0, vf, "final_fetch");

        #20;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
